// File: rtl/sne_evt_stream_pkg.sv
// Shared types and constants for the event-stream kernel sweep.
// Geometry constants here match the sequencer's default parameters.
package sne_evt_stream_pkg;

  localparam int unsigned KERN_SIZE = 3;
  localparam int unsigned GRID_EDGE = 8;
  localparam int unsigned COORD_W   = $clog2(GRID_EDGE);
  localparam int unsigned TGT_W     = COORD_W + 2;
  localparam int unsigned KIDX_W    = $clog2(KERN_SIZE);
  localparam int unsigned WIDX_W    = 4;
  localparam int unsigned SEQ_W     = 8;
  localparam int unsigned SWEEP_LEN = KERN_SIZE * KERN_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq_addr;
    logic [WIDX_W-1:0] weight_idx;
  } kernel_beat_t;

endpackage

// File: rtl/evt_kernel_addr_gen.sv
// Maps one kernel position of an event to its target address,
// weight index and in-grid flag.
module evt_kernel_addr_gen
  import sne_evt_stream_pkg::*;
#(
  parameter int GRID_SIZE   = GRID_EDGE,
  parameter int KERNEL_SIZE = KERN_SIZE
) (
  input  logic [COORD_W-1:0] xi,
  input  logic [COORD_W-1:0] yi,
  input  logic [COORD_W-1:0] x_offset,
  input  logic [COORD_W-1:0] y_offset,
  input  logic [KIDX_W-1:0]  kx,
  input  logic [KIDX_W-1:0]  ky,
  output logic               valid,
  output kernel_beat_t       beat
);

  localparam logic signed [TGT_W-1:0] LO = TGT_W'(1);
  localparam logic signed [TGT_W-1:0] HI = TGT_W'(GRID_SIZE - 2);
  localparam logic [WIDX_W-1:0] KS = WIDX_W'(KERNEL_SIZE);
  localparam int PAD = SEQ_W / 2 - COORD_W;

  logic signed [TGT_W-1:0] tx;
  logic signed [TGT_W-1:0] ty;

  // Two guard bits keep the sum exact; border neurons are excluded.
  always_comb begin
    tx = TGT_W'(xi) + TGT_W'(x_offset) + LO - TGT_W'(kx);
    ty = TGT_W'(yi) + TGT_W'(y_offset) + LO - TGT_W'(ky);
    valid = (tx >= LO) && (tx <= HI)
         && (ty >= LO) && (ty <= HI);
    beat.seq_addr = {{PAD{1'b0}}, ty[COORD_W-1:0],
                     {PAD{1'b0}}, tx[COORD_W-1:0]};
    beat.weight_idx = WIDX_W'(ky) * KS + WIDX_W'(kx);
  end

endmodule

// File: rtl/evt_kernel_sweep_sequencer.sv
// Per-event kernel window sweep: one registered beat per in-grid
// target, ky outer / kx inner, with output backpressure.
module evt_kernel_sweep_sequencer
  import sne_evt_stream_pkg::*;
#(
  parameter int SEQ_ADDR_WIDTH  = SEQ_W,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int KERNEL_SIZE     = KERN_SIZE,
  parameter int GRID_SIZE       = GRID_EDGE,
  parameter int GROUP_ID        = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic [COORD_W-1:0]         x_offset_i,
  input  logic [COORD_W-1:0]         y_offset_i,
  input  logic                       evt_valid_i,
  output logic                       evt_ready_o,
  input  logic [NEURON_ID_WIDTH-1:0] evt_addr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SEQ_ADDR_WIDTH-1:0]  seq_addr_o,
  output logic [WIDX_W-1:0]          weight_idx_o,
  output logic                       kernel_clk_en_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int HALF = NEURON_ID_WIDTH / 2;
  localparam logic [KIDX_W-1:0] K_MAX = KIDX_W'(KERNEL_SIZE - 1);

  seq_state_e state, state_nx;
  logic [COORD_W-1:0] xi, yi, xo, yo;
  logic [KIDX_W-1:0] kx, ky;
  logic last_q;
  logic adv, accept, last_pos;
  logic pos_valid;
  kernel_beat_t pos_beat;
  logic unused_bits;

  assign unused_bits = ^{evt_addr_i[HALF-1:COORD_W],
                         evt_addr_i[NEURON_ID_WIDTH-1:HALF+COORD_W],
                         8'(GROUP_ID)};

  assign evt_ready_o = (state == IDLE) && enable_i
                    && !flush_i && !rst_i;
  assign accept   = evt_valid_i && evt_ready_o;
  assign adv      = !out_valid_o || out_ready_i;
  assign last_pos = (kx == K_MAX) && (ky == K_MAX);

  assign kernel_clk_en_o = (state == SWEEP);
  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);

  evt_kernel_addr_gen #(
    .GRID_SIZE   (GRID_SIZE),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_addr_gen (
    .xi       (xi),
    .yi       (yi),
    .x_offset (xo),
    .y_offset (yo),
    .kx       (kx),
    .ky       (ky),
    .valid    (pos_valid),
    .beat     (pos_beat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SWEEP;
      SWEEP:   if (adv && last_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_i) state_nx = IDLE;
  end

  // last_q marks that every position has been issued; the sweep
  // leaves only once the final beat slot drains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xi           <= '0;
      yi           <= '0;
      xo           <= '0;
      yo           <= '0;
      kx           <= '0;
      ky           <= '0;
      last_q       <= 1'b0;
      out_valid_o  <= 1'b0;
      seq_addr_o   <= '0;
      weight_idx_o <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      xi     <= evt_addr_i[COORD_W-1:0];
      yi     <= evt_addr_i[HALF+COORD_W-1:HALF];
      xo     <= x_offset_i;
      yo     <= y_offset_i;
      kx     <= '0;
      ky     <= '0;
      last_q <= 1'b0;
    end else if (state == SWEEP && adv) begin
      if (last_q) begin
        out_valid_o <= 1'b0;
      end else begin
        out_valid_o <= pos_valid;
        if (pos_valid) begin
          seq_addr_o   <= SEQ_ADDR_WIDTH'(pos_beat.seq_addr);
          weight_idx_o <= pos_beat.weight_idx;
        end
        if (last_pos) begin
          last_q <= 1'b1;
        end else if (kx == K_MAX) begin
          kx <= '0;
          ky <= ky + 1'b1;
        end else begin
          kx <= kx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_evt_kernel_sweep_sequencer.sv
// Directed bench with a queue model of the expected beat stream.
module tb_evt_kernel_sweep_sequencer;

  typedef struct {
    logic [7:0] a;
    logic [3:0] w;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flush;
  logic [2:0] x_offset;
  logic [2:0] y_offset;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_addr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] seq_addr;
  logic [3:0] weight_idx;
  logic       kernel_clk_en;
  logic       busy;
  logic       done;

  evt_kernel_sweep_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .flush_i         (flush),
    .x_offset_i      (x_offset),
    .y_offset_i      (y_offset),
    .evt_valid_i     (evt_valid),
    .evt_ready_o     (evt_ready),
    .evt_addr_i      (evt_addr),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .seq_addr_o      (seq_addr),
    .weight_idx_o    (weight_idx),
    .kernel_clk_en_o (kernel_clk_en),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;
  beat_t exp_q[$];
  beat_t log_q[$];
  logic done_exp = 1'b0;
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string name, input int act, input int req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected beats straight from the window arithmetic.
  task automatic model(input int x, input int y, input int xo,
                       input int yo, output int n);
    n = 0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        int tx, ty;
        tx = x + 1 + xo - kx;
        ty = y + 1 + yo - ky;
        if (tx >= 1 && tx <= 6 && ty >= 1 && ty <= 6) begin
          beat_t b;
          b.a = 8'((ty << 4) | tx);
          b.w = 4'(ky * 3 + kx);
          exp_q.push_back(b);
          n++;
        end
      end
    end
  endtask

  logic       pstall = 1'b0;
  logic [7:0] pa;
  logic [3:0] pw;

  always @(negedge clk) begin
    if (rst) begin
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_addr", int'(seq_addr), int'(pa));
        check("hold_widx", int'(weight_idx), int'(pw));
      end
      if (out_valid && out_ready) begin
        beat_t got;
        got.a = seq_addr;
        got.w = weight_idx;
        log_q.push_back(got);
        check("beat_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("beat_addr", int'(seq_addr), int'(exp_q[0].a));
          check("beat_widx", int'(weight_idx), int'(exp_q[0].w));
          void'(exp_q.pop_front());
        end
      end
      pstall = out_valid && !out_ready;
      pa = seq_addr;
      pw = weight_idx;
      if (done) begin
        check("done_expected", int'(done_exp), 1);
        check("done_all_beats", exp_q.size(), 0);
        check("done_busy", int'(busy), 1);
        done_exp = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic send_event(input int x, input int y, input int xo,
                            input int yo, output int t, output int n);
    int acc;
    acc = 0;
    t = 0;
    log_q.delete();
    @(posedge clk);
    #1;
    evt_valid = 1'b1;
    evt_addr = 8'(((y & 7) << 4) | (x & 7));
    x_offset = 3'(xo);
    y_offset = 3'(yo);
    model(x, y, xo, yo, n);
    done_exp = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (evt_ready) begin
        acc = 1;
        t = cyc + 1;
        break;
      end
    end
    check("evt_accepted", acc, 1);
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
    evt_addr = 8'h77;
    x_offset = 3'd5;
    y_offset = 3'd6;
  endtask

  task automatic wait_done(input int limit, output int dc);
    int c0;
    c0 = done_cnt;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done_cnt != c0) break;
    end
    check("done_seen", int'(done_cnt != c0), 1);
    dc = done_cyc;
  endtask

  logic [7:0] t1a [9];
  logic [3:0] t1w [9];
  logic [7:0] t3a [3];
  logic [3:0] t3w [3];

  initial begin
    int t, n, dc, c0;
    t1a = '{8'h44, 8'h43, 8'h42, 8'h34, 8'h33, 8'h32,
            8'h24, 8'h23, 8'h22};
    t1w = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    t3a = '{8'h46, 8'h36, 8'h26};
    t3w = '{4'd2, 4'd5, 4'd8};

    rst = 1'b1;
    enable = 1'b1;
    flush = 1'b0;
    x_offset = '0;
    y_offset = '0;
    evt_valid = 1'b0;
    evt_addr = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(evt_ready), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_addr", int'(seq_addr), 0);
    check("rst_widx", int'(weight_idx), 0);
    check("rst_kclk", int'(kernel_clk_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready_en", int'(evt_ready), 1);
    enable = 1'b0;
    #1 check("idle_ready_dis", int'(evt_ready), 0);
    enable = 1'b1;

    // Centre event, no offsets
    send_event(3, 3, 0, 0, t, n);
    check("t1_model_n", n, 9);
    @(negedge clk);
    check("t1_kclk", int'(kernel_clk_en), 1);
    check("t1_busy", int'(busy), 1);
    wait_done(40, dc);
    check("t1_latency", dc - t, 10);
    check("t1_count", log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++) begin
      check("t1_lit_addr", int'(log_q[i].a), int'(t1a[i]));
      check("t1_lit_widx", int'(log_q[i].w), int'(t1w[i]));
    end
    @(negedge clk);
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_ready", int'(evt_ready), 1);

    // Corner event
    send_event(0, 0, 0, 0, t, n);
    wait_done(40, dc);
    check("t2_latency", dc - t, 10);
    check("t2_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("t2_lit_addr", int'(log_q[0].a), 'h11);
      check("t2_lit_widx", int'(log_q[0].w), 0);
    end

    // x offset pushes most columns off-grid
    send_event(0, 3, 7, 0, t, n);
    wait_done(40, dc);
    check("t3_latency", dc - t, 10);
    check("t3_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check("t3_lit_addr", int'(log_q[i].a), int'(t3a[i]));
      check("t3_lit_widx", int'(log_q[i].w), int'(t3w[i]));
    end

    // Backpressure on the second beat
    send_event(3, 3, 0, 0, t, n);
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    check("t4_stall_widx", int'(weight_idx), 1);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(40, dc);
    check("t4_latency", dc - t, 13);
    check("t4_count", log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++)
      check("t4_lit_addr", int'(log_q[i].a), int'(t1a[i]));

    // Flush on the fourth beat
    c0 = done_cnt;
    send_event(3, 3, 0, 0, t, n);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    check("t5_beat4_widx", int'(weight_idx), 3);
    @(posedge clk);
    #1 flush = 1'b0;
    exp_q.delete();
    done_exp = 1'b0;
    @(negedge clk);
    check("t5_valid_low", int'(out_valid), 0);
    check("t5_busy_low", int'(busy), 0);
    check("t5_ready", int'(evt_ready), 1);
    repeat (15) @(negedge clk);
    check("t5_no_done", done_cnt - c0, 0);
    send_event(2, 2, 0, 0, t, n);
    wait_done(40, dc);
    check("t5_latency", dc - t, 10);
    check("t5_count", log_q.size(), 9);

    // Asynchronous reset mid-sweep
    send_event(3, 3, 0, 0, t, n);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_valid", int'(out_valid), 0);
    check("t6_addr", int'(seq_addr), 0);
    check("t6_widx", int'(weight_idx), 0);
    check("t6_kclk", int'(kernel_clk_en), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_ready", int'(evt_ready), 0);
    exp_q.delete();
    done_exp = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_ready_after", int'(evt_ready), 1);
    send_event(4, 4, 1, 2, t, n);
    wait_done(40, dc);
    check("t6_latency", dc - t, 10);
    check("t6_count", log_q.size(), n);
    check("t6_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
